instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries; a power of two, at least 2.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: request fields valid.
REQ-005 SHALL have port in_ready, output, 1: encoder can accept a request.
REQ-006 SHALL have ports in_opcode (input, 7, opcode_e) and in_imm_type (input, 3, imm_type_e).
REQ-007 SHALL have ports in_rd, in_rs1 and in_rs2 (input, 5 each), in_funct3 (input, 3) and in_funct7 (input, 7).
REQ-008 SHALL have port in_imm, input, 32: two's-complement immediate; for IMM_U, the full 32-bit value.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1) forming the encoded-word handshake.
REQ-010 SHALL have ports out_instr (output, 32), the encoded word, and out_err (output, 1), the encoding error for that word.
REQ-011 SHALL have ports enc_count (output, 16), words delivered, and err_count (output, 16), erroneous words delivered.

Function
REQ-012 SHALL accept a request on a clock edge where in_valid=1 and in_ready=1.
REQ-013 SHALL drive in_ready = FIFO not full, with no combinational path from out_ready.
REQ-014 SHALL encode IMM_NONE as R format: funct7, rs2, rs1, funct3, rd, opcode.
REQ-015 SHALL encode IMM_I as imm[11:0], rs1, funct3, rd, opcode.
REQ-016 SHALL encode IMM_S as imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
REQ-017 SHALL encode IMM_B as imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
REQ-018 SHALL encode IMM_U as imm[31:12], rd, opcode.
REQ-019 SHALL encode IMM_J as imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
REQ-020 SHALL, for reserved imm_type (3'b101, 3'b110), store out_instr=32'h0 with out_err=1.
REQ-021 SHALL store the encoded word and its error bit in a FIFO_DEPTH-entry FIFO; out_valid = FIFO not empty; out_instr and out_err come from the head entry.
REQ-022 SHALL have a latency of 1 cycle: a request accepted at edge N into an empty FIFO gives out_valid=1 immediately after edge N.
REQ-023 SHALL hold out_instr and out_err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL pop the head on an edge where out_valid=1 and out_ready=1.
REQ-025 SHALL, on a simultaneous push and pop, leave occupancy unchanged and preserve order.
REQ-026 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-027 SHALL increment enc_count on each output handshake, and err_count on each output handshake with out_err=1; both saturate at 16'hFFFF.
REQ-028 SHALL ignore opcode/funct legality; only imm_type selects the format.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, in_ready=0, out_instr=0, out_err=0, enc_count=0, err_count=0, and empty the FIFO.
REQ-030 SHALL, on reset mid-operation, discard all buffered words with no handshake counted.
REQ-031 SHALL assert in_ready on the first edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with INSTR_ENC_RANGE_CHECK_EN defined, set out_err=1 on any of: I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or odd; J imm outside [-1048576,1048574] or odd; U imm[11:0]≠0.
REQ-033 SHALL, with INSTR_ENC_RANGE_CHECK_EN defined, still encode such a word with the truncated bits.
REQ-034 SHALL, with INSTR_ENC_RANGE_CHECK_EN undefined, omit range-check logic, so out_err is set only by REQ-020.

Verification
REQ-035 SHALL cover: IMM_I, opcode 0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr 32'h00500093, out_err 0.
REQ-036 SHALL cover: IMM_NONE, opcode 0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> 32'h002081B3.
REQ-037 SHALL cover: IMM_B, opcode 1100011, rs1=1, rs2=2, f3=0, imm=-4 -> 32'hFE208EE3; and IMM_J, opcode 1101111, rd=1, imm=8 -> 32'h008000EF.
REQ-038 SHALL cover: out_ready=0, two accepts (depth 2) -> in_ready=0 and out_instr holds the first word; then out_ready=1 -> words emerge in order and enc_count=2.
REQ-039 SHALL cover: IMM_I, imm=2048 -> out_instr 32'h80000093; out_err=1 and err_count=1 with the macro, out_err=0 and err_count=0 without it.
REQ-040 SHALL cover: rst_n pulsed low with the FIFO full -> out_valid=0, enc_count=0 at once, and in_ready=1 after the first edge.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Builds a 32-bit RISC-V style instruction word from its separate fields.
// The encoded words go into a small FIFO and leave through a valid/ready
// handshake. The block also counts delivered words and delivered error words.
//
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN
//   When this macro is defined, out_err is also raised when an immediate does
//   not fit its format. The word is still encoded from the truncated
//   immediate bits. When the macro is undefined, out_err only flags the
//   reserved imm_type codes.
//
// Parameters
//   FIFO_DEPTH  : number of output buffer entries (power of two, >= 2)
//
// Ports
//   clk         : clock; all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : request fields are valid
//   in_ready    : encoder can accept a request (FIFO not full)
//   in_opcode   : 7-bit opcode field
//   in_imm_type : selects the instruction format
//   in_rd/in_rs1/in_rs2/in_funct3/in_funct7 : register and function fields
//   in_imm      : two's-complement immediate (full 32-bit value for IMM_U)
//   out_valid   : head of the FIFO holds a word
//   out_ready   : consumer accepts the head word
//   out_instr   : encoded word at the head of the FIFO
//   out_err     : encoding error flag for that word
//   enc_count   : delivered words (saturates at 16'hFFFF)
//   err_count   : delivered words with out_err set (saturates at 16'hFFFF)
// ---------------------------------------------------------------------------

typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
} opcode_e;

// Codes 3'b101 and 3'b110 are reserved and produce an error word.
typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_U    = 3'b100,
    IMM_J    = 3'b111
} imm_type_e;

module instr_encoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  opcode_e     in_opcode,
    input  imm_type_e   in_imm_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          live;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   enc_word;
    logic          enc_err;
    logic          range_bad;

    // Bit placement for each format. Opcode and funct legality are ignored.
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (in_imm_type)
            IMM_NONE: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            IMM_I:    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            IMM_S:    enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            IMM_B:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                  in_imm[4:1], in_imm[11], in_opcode};
            IMM_U:    enc_word = {in_imm[31:12], in_rd, in_opcode};
            IMM_J:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                  in_rd, in_opcode};
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
        enc_err = enc_err | range_bad;
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // A signed value fits when every bit from the sign position upward agrees.
    // B and J offsets must also be even because bit 0 is not encoded.
    always_comb begin
        range_bad = 1'b0;
        case (in_imm_type)
            IMM_I, IMM_S: range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            IMM_B:        range_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            IMM_J:        range_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            IMM_U:        range_bad = |in_imm[11:0];
            default:      range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    // in_ready is held low until the first edge after reset. It depends only
    // on registered state, so there is no combinational path from out_ready.
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = live & ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The outputs are gated by out_valid. This keeps them at zero during reset
    // and when the FIFO is empty, without clearing the storage array.
    assign out_instr = out_valid ? mem[rd_ptr][31:0] : 32'h0;
    assign out_err   = out_valid & mem[rd_ptr][32];

    // The storage array needs no reset because the occupancy count controls
    // which entries are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc_err, enc_word};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Delivery counters saturate at 16'hFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (pop) begin
            if (enc_count != 16'hFFFF) begin
                enc_count <= enc_count + 16'd1;
            end
            if (out_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A behavioural model builds the
// expected words with shifts and masks, holds the FIFO contents in a queue,
// and tracks the delivery counters.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    opcode_e     in_opcode;
    imm_type_e   in_imm_type;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

    logic [32:0] mdl_q[$];
    int          mdl_enc;
    int          mdl_err;
    bit          mdl_live;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam logic RANGE_ON = 1'b1;
`else
    localparam logic RANGE_ON = 1'b0;
`endif

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_imm_type(in_imm_type),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Reference model of the range check, written as signed integer bounds.
    function automatic bit ref_range_bad(input logic [2:0] t, input logic [31:0] imm);
        int s;
        s = int'(signed'(imm));
        case (t)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4094) || (imm[0] == 1'b1);
            3'd7:       return (s < -1048576) || (s > 1048574) || (imm[0] == 1'b1);
            3'd4:       return (imm & 32'hFFF) != 32'h0;
            default:    return 1'b0;
        endcase
    endfunction

    // Reference encoding: each field is masked and then shifted into place.
    function automatic logic [32:0] ref_encode(input logic [2:0] t, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic        e;
        logic [31:0] regs;
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        e = 1'b0;
        case (t)
            3'd0: w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
            3'd1: w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (32'(rd) << 7) | 32'(op);
            3'd2: w = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(op);
            3'd3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
            3'd4: w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            3'd7: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7) | 32'(op);
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
        if (RANGE_ON && ref_range_bad(t, imm)) e = 1'b1;
        return {e, w};
    endfunction

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_imm_type = imm_type_e'(t);
        in_opcode   = opcode_e'(op);
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_funct3   = f3;
        in_funct7   = f7;
        in_imm      = imm;
    endtask

    task automatic mdl_reset();
        mdl_q.delete();
        mdl_enc  = 0;
        mdl_err  = 0;
        mdl_live = 1'b0;
    endtask

    // Advances one clock edge and applies the handshakes to the model. The
    // task returns 1 time unit after the edge.
    task automatic tick();
        bit push;
        bit pop;
        push = in_valid && mdl_live && (mdl_q.size() < DEPTH);
        pop  = (mdl_q.size() != 0) && out_ready;
        @(posedge clk);
        if (pop) begin
            if (mdl_q[0][32] && mdl_err < 65535) mdl_err++;
            if (mdl_enc < 65535) mdl_enc++;
            void'(mdl_q.pop_front());
        end
        if (push) begin
            mdl_q.push_back(ref_encode(in_imm_type, in_opcode, in_rd, in_rs1, in_rs2,
                                       in_funct3, in_funct7, in_imm));
        end
        mdl_live = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #3;
        rst_n    = 1'b1;
        mdl_reset();
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, in_ready, out_instr, out_err, enc_count, err_count} !== 67'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%0b ready=%0b instr=%h err=%0b enc=%0d errc=%0d, want all zero",
                     out_valid, in_ready, out_instr, out_err, enc_count, err_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_before_edge: got %0b want 0", in_ready);
        end
        mdl_reset();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_after_edge: got ready=%0b valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] exp_w;
        logic        exp_e;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
                         exp_w = 32'h00500093; exp_e = 1'b0; end
                1: begin set_req(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
                         exp_w = 32'h002081B3; exp_e = 1'b0; end
                2: begin set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
                         exp_w = 32'hFE208EE3; exp_e = 1'b0; end
                3: begin set_req(3'd7, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
                         exp_w = 32'h008000EF; exp_e = 1'b0; end
                default: begin set_req(3'b101, 7'b0010011, 5'd7, 5'd3, 5'd4, 3'd1, 7'd2, 32'd9);
                         exp_w = 32'h0; exp_e = 1'b1; end
            endcase
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_w || out_err !== exp_e) begin
                failures++;
                $display("[TB] FAIL vector%0d: got valid=%0b instr=%h err=%0b want 1 %h %0b",
                         i, out_valid, out_instr, out_err, exp_w, exp_e);
            end
            tick();
        end
    endtask

    task automatic test_range();
        apply_reset();
        out_ready = 1'b1;
        set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_instr !== 32'h80000093 || out_err !== RANGE_ON) begin
            failures++;
            $display("[TB] FAIL range_imm2048: got instr=%h err=%0b want 80000093 %0b",
                     out_instr, out_err, RANGE_ON);
        end
        tick();
        checks++;
        if (err_count !== 16'(RANGE_ON) || enc_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL range_counts: got enc=%0d err=%0d want 1 %0d",
                     enc_count, err_count, RANGE_ON);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        set_req(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        tick();
        set_req(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00100113) begin
            failures++;
            $display("[TB] FAIL full_hold: got ready=%0b valid=%0b instr=%h want 0 1 00100113",
                     in_ready, out_valid, out_instr);
        end
        tick();
        checks++;
        if (out_instr !== 32'h00100113) begin
            failures++;
            $display("[TB] FAIL stall_stable: got %h want 00100113", out_instr);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_instr !== 32'h123452B7 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL second_word: got valid=%0b instr=%h want 1 123452B7", out_valid, out_instr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || enc_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL drain: got valid=%0b enc=%0d want 0 2", out_valid, enc_count);
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        out_ready = 1'b1;
        set_req(3'd0, 7'b0110011, 5'd9, 5'd8, 5'd7, 3'd2, 7'd32, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || enc_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL prefill: got ready=%0b enc=%0d want 0 1", in_ready, enc_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || enc_count !== 16'd0 || in_ready !== 1'b0 || out_instr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midop_reset: got valid=%0b enc=%0d ready=%0b instr=%h want 0 0 0 0",
                     out_valid, enc_count, in_ready, out_instr);
        end
        rst_n = 1'b1;
        mdl_reset();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || enc_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL post_reset: got ready=%0b valid=%0b enc=%0d want 1 0 0",
                     in_ready, out_valid, enc_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] imm;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom), 7'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            checks++;
            if (in_ready !== (mdl_live && mdl_q.size() < DEPTH) || out_valid !== (mdl_q.size() != 0)) begin
                failures++;
                $display("[TB] FAIL rand_flags[%0d]: got ready=%0b valid=%0b, model occupancy %0d",
                         n, in_ready, out_valid, mdl_q.size());
            end
            if (mdl_q.size() != 0) begin
                checks++;
                if (out_instr !== mdl_q[0][31:0] || out_err !== mdl_q[0][32]) begin
                    failures++;
                    $display("[TB] FAIL rand_word[%0d]: got %h/%0b want %h/%0b",
                             n, out_instr, out_err, mdl_q[0][31:0], mdl_q[0][32]);
                end
            end
            checks++;
            if (enc_count !== 16'(mdl_enc) || err_count !== 16'(mdl_err)) begin
                failures++;
                $display("[TB] FAIL rand_counts[%0d]: got enc=%0d err=%0d want %0d %0d",
                         n, enc_count, err_count, mdl_enc, mdl_err);
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        mdl_reset();
        #12;
        test_reset();
        test_vectors();
        test_range();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
